cbrt_param: RTL and testbench
=============================

# cbrt_param

Parametrised integer cube-root unit, successor to the fixed 8-bit `cbrt` block. It computes floor(cbrt(x)) and the remainder x − result³ for an unsigned operand of configurable width, using a digit-by-digit restoring algorithm. Latency is fixed and determined by the parameter. It has no dependency on the shared `mul` block and sits in the same start/busy-style arithmetic datapath, with an added one-cycle `done` strobe.

## Interface

- `WIDTH`, default 8: operand width in bits, ≥ 3.
- Derived localparam: `OUT_W` = ceil(WIDTH/3), the result width and also the iteration count `ITER`.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; accepted only when sampled high with `busy` low.
- `x_i`  in  WIDTH: unsigned operand, sampled at the accepting edge only.
- `busy`  out  1: computation in progress.
- `done`  out  1: one-cycle pulse when `result`/`rem_o` update.
- `result`  out  OUT_W: floor(cbrt(x)).
- `rem_o`  out  WIDTH: x − result³.

## Operation

- States: IDLE, SHIFT, TEST.
- IDLE:
  - On `start` & !`busy`: latch `x_i` into `xr`, set y = 0 and i = ITER−1, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT: y ← 2y, then go to TEST.
- TEST:
  - Compute b = (3·y·(y+1) + 1) << 3i in an internal width of 3·OUT_W+2 bits. No truncation is permitted.
  - If `xr` ≥ b: `xr` ← `xr` − b and y ← y + 1.
  - If i = 0: write `result` ← y (final value) and `rem_o` ← `xr` (final value), pulse `done`, return to IDLE.
  - Otherwise: i ← i − 1, go to SHIFT.
- Multiplication is combinational, inside the block, and fits within one cycle.
- `start` while busy is ignored; it is not queued.
- `x_i` changes after acceptance have no effect.
- `result` and `rem_o` hold their values until the next completion or reset. They are not cleared on a new `start`.
- Invariants at completion: result³ ≤ x < (result+1)³, and rem_o ≤ 3·result² + 3·result.
- Reset (async, any state):
  - state = IDLE, `busy` = 0, `done` = 0, `result` = 0, `rem_o` = 0.
  - Internal `xr`, y and i are cleared.
  - A computation aborted by reset produces no `done`.

## Timing

- Accepting edge is E (start=1, busy=0 sampled).
- `busy` = 1 from after E through edge E+2·ITER.
- At edge E+2·ITER:
  - `busy` falls.
  - `done` rises.
  - `result` and `rem_o` take their final values.
- `done` is high for exactly one cycle and falls at E+2·ITER+1.
- Latency in busy cycles:
  - WIDTH=8: ITER=3, busy for 6 cycles.
  - WIDTH=16: ITER=6, busy for 12 cycles.
- Back-to-back: `start` sampled high at E+2·ITER is not accepted, because busy=1 before that edge. The earliest accept is E+2·ITER+1, giving one idle cycle between jobs.
- Reset release: the first accept is allowed at the first rising edge with `rst` high.

## Test plan

- WIDTH=8, x=27 → result=3, rem=0; busy for exactly 6 cycles; `done` high for 1 cycle.
- WIDTH=8, sweep x=0..255 → result and rem match the reference model (255 → 6/39, 216 → 6/0, 0 → 0/0, 7 → 1/6).
- WIDTH=8, pulse start with x=64; re-pulse start with x=125 on cycle 3 of busy → second start ignored; result=4, rem=0; then a fresh start with x=125 → 5/0.
- WIDTH=8, start with x=200; assert `rst` low asynchronously between edges at cycle 4 → `busy`, `done`, `result` and `rem_o` go to 0 immediately with no clock; no `done` after release; next job with x=8 → 2/0.
- WIDTH=16, x=65535 → result=40, rem=1535, busy for 12 cycles; x=64000 → 40/0; x=1 → 1/0.
- WIDTH=8, hold start high continuously with x=27 → jobs accepted every 7 cycles; each `done` shows 3/0.

Source files
------------

// File: rtl/cbrt_param.sv
// Parametrised integer cube root: floor(cbrt(x)) plus remainder x - result^3,
// one restoring digit per SHIFT/TEST pair, fixed latency of 2*ITER cycles.
module cbrt_param #(
    parameter int  WIDTH = 8,
    localparam int OUT_W = (WIDTH + 2) / 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_i,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic [WIDTH-1:0] rem_o
);
    localparam int ITER = OUT_W;
    localparam int BW   = 3 * OUT_W + 2;
    localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, TEST} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] xr;
    logic [OUT_W-1:0] y;
    logic [IW-1:0]    i;

    logic [BW-1:0]    yw, base, b;
    logic [IW+1:0]    sh;
    logic             ge;
    logic [WIDTH-1:0] xr_sub;
    logic [OUT_W-1:0] y_inc;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   state_nxt = TEST;
            TEST:    state_nxt = (i == '0) ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // Trial subtrahend (3y(y+1)+1) << 3i, held wide enough that no bit is lost.
    always_comb begin
        yw     = BW'(y);
        sh     = {1'b0, i, 1'b0} + {2'b00, i};
        base   = ((yw << 1) + yw) * (yw + BW'(1)) + BW'(1);
        b      = base << sh;
        ge     = BW'(xr) >= b;
        xr_sub = xr - b[WIDTH-1:0];
        y_inc  = y + OUT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xr     <= '0;
            y      <= '0;
            i      <= '0;
            done   <= 1'b0;
            result <= '0;
            rem_o  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    xr <= x_i;
                    y  <= '0;
                    i  <= IW'(ITER - 1);
                end
                SHIFT: y <= y << 1;
                TEST: begin
                    if (ge) begin
                        xr <= xr_sub;
                        y  <= y_inc;
                    end
                    if (i == '0) begin
                        result <= ge ? y_inc : y;
                        rem_o  <= ge ? xr_sub : xr;
                        done   <= 1'b1;
                    end else begin
                        i <= i - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cbrt_param.sv
// Scoreboard bench for cbrt_param at WIDTH=8 and WIDTH=16; expected values come
// from a brute-force integer cube root and the start/busy acceptance rule.
module tb_cbrt_param;
    logic clk = 1'b0;
    logic rst;
    logic start8, start16;
    logic [7:0]  x8;
    logic [15:0] x16;
    logic busy8, done8, busy16, done16;
    logic [2:0]  res8;
    logic [7:0]  rem8;
    logic [5:0]  res16;
    logic [15:0] rem16;

    cbrt_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .x_i(x8),
        .busy(busy8), .done(done8), .result(res8), .rem_o(rem8)
    );
    cbrt_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .x_i(x16),
        .busy(busy16), .done(done16), .result(res16), .rem_o(rem16)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint x;
        longint r;
        longint m;
        longint acc;
    } exp_t;

    exp_t   q8[$], q16[$];
    int     n_chk = 0, n_fail = 0;
    longint cyc = 0;
    int     run8 = 0, run16 = 0;
    logic   prev_done8 = 1'b0, prev_done16 = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t model(input longint x, input longint acc);
        exp_t   e;
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        e.x = x; e.r = r; e.m = x - r * r * r; e.acc = acc;
        return e;
    endfunction

    // Monitors: compare on every done strobe.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk("done8_single_cycle", prev_done8, 0);
            chk("busy8_low_at_done", busy8, 0);
            if (q8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done8_unexpected actual=done(%0d/%0d) required=no done", res8, rem8);
            end else begin
                e = q8.pop_front();
                chk($sformatf("res8 x=%0d", e.x), res8, e.r);
                chk($sformatf("rem8 x=%0d", e.x), rem8, e.m);
                chk("lat8", cyc - e.acc, 6);
                chk("busy8_cycles", run8, 6);
            end
        end
        run8 = busy8 ? run8 + 1 : 0;
        prev_done8 = done8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done16) begin
            chk("done16_single_cycle", prev_done16, 0);
            if (q16.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done16_unexpected actual=done(%0d/%0d) required=no done", res16, rem16);
            end else begin
                e = q16.pop_front();
                chk($sformatf("res16 x=%0d", e.x), res16, e.r);
                chk($sformatf("rem16 x=%0d", e.x), rem16, e.m);
                chk("lat16", cyc - e.acc, 12);
                chk("busy16_cycles", run16, 12);
            end
        end
        run16 = busy16 ? run16 + 1 : 0;
        prev_done16 = done16;
    end

    // One negedge of drive; an accept is predicted when start meets busy low.
    task automatic cyc8(input logic s, input int x, output logic acc);
        @(negedge clk);
        start8 = s;
        x8 = x[7:0];
        acc = s && !busy8 && rst;
        if (acc) q8.push_back(model(x & 255, cyc + 1));
    endtask

    task automatic issue8(input int x);
        logic a = 1'b0;
        for (int k = 0; k < 50 && !a; k++) cyc8(1'b1, x, a);
        if (!a) begin n_chk++; n_fail++; $display("FAIL issue8_timeout actual=busy required=accept"); end
        cyc8(1'b0, x, a);
    endtask

    task automatic issue16(input int x);
        logic a = 1'b0;
        for (int k = 0; k < 50 && !a; k++) begin
            @(negedge clk);
            start16 = 1'b1;
            x16 = x[15:0];
            a = !busy16;
            if (a) q16.push_back(model(x & 65535, cyc + 1));
        end
        if (!a) begin n_chk++; n_fail++; $display("FAIL issue16_timeout actual=busy required=accept"); end
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic drain(input int n);
        logic a;
        for (int k = 0; k < n; k++) cyc8(1'b0, 0, a);
    endtask

    initial begin
        logic   a;
        longint last;
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0; x8 = '0; x16 = '0;
        #1;
        chk("rst_busy8", busy8, 0);   chk("rst_done8", done8, 0);
        chk("rst_res8", res8, 0);     chk("rst_rem8", rem8, 0);
        chk("rst_busy16", busy16, 0); chk("rst_done16", done16, 0);
        chk("rst_res16", res16, 0);   chk("rst_rem16", rem16, 0);
        #20;
        @(negedge clk) rst = 1'b1;

        // Single job straight after reset release.
        issue8(27);
        drain(8);

        // Full sweep, back to back.
        for (int x = 0; x < 256; x++) issue8(x);
        drain(8);

        // A start during busy is dropped; x_i changes after accept are ignored.
        issue8(64);
        cyc8(1'b0, 200, a);
        cyc8(1'b0, 200, a);
        cyc8(1'b1, 125, a);
        chk("start8_while_busy_ignored", a, 0);
        cyc8(1'b0, 125, a);
        issue8(125);
        drain(8);

        // Asynchronous reset mid-computation.
        issue8(200);
        cyc8(1'b0, 0, a);
        cyc8(1'b0, 0, a);
        cyc8(1'b0, 0, a);
        @(posedge clk);
        #2 rst = 1'b0;
        q8.delete();
        #1;
        chk("arst_busy8", busy8, 0); chk("arst_done8", done8, 0);
        chk("arst_res8", res8, 0);   chk("arst_rem8", rem8, 0);
        #20;
        @(negedge clk) rst = 1'b1;
        drain(10);
        issue8(8);
        drain(8);

        // Start held high: accept every 2*ITER+1 cycles.
        last = -1;
        for (int k = 0; k < 30; k++) begin
            cyc8(1'b1, 27, a);
            if (a) begin
                if (last >= 0) chk("hold8_spacing", cyc + 1 - last, 7);
                last = cyc + 1;
            end
        end
        cyc8(1'b0, 0, a);
        drain(8);

        // Random operands on both widths.
        for (int k = 0; k < 40; k++) issue8(int'($urandom_range(0, 255)));
        drain(8);
        issue16(65535);
        issue16(64000);
        issue16(1);
        issue16(0);
        for (int k = 0; k < 40; k++) issue16(int'($urandom_range(0, 65535)));
        for (int k = 0; k < 20 && (q8.size() != 0 || q16.size() != 0); k++) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
